// File: rtl/ime_best_mv_pkg.sv
// ime_best_mv_pkg: shared widths, partition indices, FSM states and cost saturation
package ime_best_mv_pkg;
  localparam int MV_LEN = 7;
  localparam int LAMBDA_LEN = 6;
  localparam int COST_LEN = 16;
  localparam int SAD4X4_NUM = 16;
  localparam int SAD4X4_LEN = 13;
  localparam int SAD8_LEN = SAD4X4_LEN + 2;
  localparam int PSAD_LEN = COST_LEN + 2;
  localparam int PART_NUM = 9;
  localparam int P16X16 = 0;
  localparam int P16X8_0 = 1;
  localparam int P16X8_1 = 2;
  localparam int P8X16_0 = 3;
  localparam int P8X16_1 = 4;
  localparam int P8X8_0 = 5;
  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN} state_t;
  function automatic logic [COST_LEN-1:0] sat_cost(input logic [PSAD_LEN-1:0] v);
    return |v[PSAD_LEN-1:COST_LEN] ? {COST_LEN{1'b1}} : v[COST_LEN-1:0];
  endfunction
endpackage

// File: rtl/ime_best_mv_if.sv
// ime_best_mv_if: candidate stream in, per-partition winners out
interface ime_best_mv_if;
  import ime_best_mv_pkg::*;
  logic start_i, valid_i, last_i;
  logic [SAD4X4_NUM*SAD4X4_LEN-1:0] sad4x4_i;
  logic [MV_LEN-1:0] mv_x_i, mv_y_i, pmv_x_i, pmv_y_i;
  logic [LAMBDA_LEN-1:0] lambda_i;
  logic busy_o, done_o;
  logic [PART_NUM*COST_LEN-1:0] best_cost_o;
  logic [PART_NUM*2*MV_LEN-1:0] best_mv_o;
  modport master (output start_i, valid_i, last_i, sad4x4_i, mv_x_i, mv_y_i, pmv_x_i, pmv_y_i, lambda_i,
                  input busy_o, done_o, best_cost_o, best_mv_o);
  modport slave (input start_i, valid_i, last_i, sad4x4_i, mv_x_i, mv_y_i, pmv_x_i, pmv_y_i, lambda_i,
                 output busy_o, done_o, best_cost_o, best_mv_o);
endinterface

// File: rtl/ime_best_mv_mv_cost.sv
// ime_mv_cost: lambda * (|mv_x-pmv_x| + |mv_y-pmv_y|), saturated to the cost width
module ime_mv_cost
  import ime_best_mv_pkg::*;
(
  input  logic [MV_LEN-1:0]     mv_x_i,
  input  logic [MV_LEN-1:0]     mv_y_i,
  input  logic [MV_LEN-1:0]     pmv_x_i,
  input  logic [MV_LEN-1:0]     pmv_y_i,
  input  logic [LAMBDA_LEN-1:0] lambda_i,
  output logic [COST_LEN-1:0]   cost_o
);
  localparam int PW = LAMBDA_LEN + MV_LEN + 2;
  logic [MV_LEN:0] dx, dy, ax, ay;
  logic [MV_LEN+1:0] dsum;
  logic [PW-1:0] prod;
  always_comb begin
    dx = {mv_x_i[MV_LEN-1], mv_x_i} - {pmv_x_i[MV_LEN-1], pmv_x_i};
    dy = {mv_y_i[MV_LEN-1], mv_y_i} - {pmv_y_i[MV_LEN-1], pmv_y_i};
    ax = dx[MV_LEN] ? -dx : dx;
    ay = dy[MV_LEN] ? -dy : dy;
    dsum = {1'b0, ax} + {1'b0, ay};
    prod = {{(MV_LEN+2){1'b0}}, lambda_i} * {{LAMBDA_LEN{1'b0}}, dsum};
    cost_o = sat_cost(PSAD_LEN'(prod));
  end
endmodule

// File: rtl/ime_best_mv.sv
// ime_best_mv: 2-stage partition SAD + MV cost, tracks per-partition minimum over a search
module ime_best_mv
  import ime_best_mv_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  ime_best_mv_if.slave bus
);
  state_t state_q, state_d;
  logic acc, s1_valid_q, s1_last_q, done_q;
  logic [SAD8_LEN-1:0] sad8_d [4];
  logic [SAD8_LEN-1:0] sad8_q [4];
  logic [COST_LEN-1:0] mvc_d, mvc_q;
  logic [2*MV_LEN-1:0] mv_q;
  logic [PSAD_LEN-1:0] psad [PART_NUM];
  logic [COST_LEN-1:0] cost [PART_NUM];
  logic [COST_LEN-1:0] best_cost_q [PART_NUM];
  logic [2*MV_LEN-1:0] best_mv_q [PART_NUM];

  ime_mv_cost u_mv_cost (
    .mv_x_i(bus.mv_x_i), .mv_y_i(bus.mv_y_i), .pmv_x_i(bus.pmv_x_i), .pmv_y_i(bus.pmv_y_i),
    .lambda_i(bus.lambda_i), .cost_o(mvc_d)
  );

  always_comb begin
    acc = bus.valid_i && (bus.start_i || state_q == SEARCH);
    state_d = (acc && bus.last_i) ? DRAIN : (bus.start_i || state_q == SEARCH) ? SEARCH : IDLE;
    for (int i = 0; i < 4; i++) begin
      sad8_d[i] = '0;
      for (int j = 0; j < 4; j++)
        sad8_d[i] += SAD8_LEN'(bus.sad4x4_i[(i*4+j)*SAD4X4_LEN +: SAD4X4_LEN]);
    end
    psad[P16X16] = PSAD_LEN'(sad8_q[0]) + PSAD_LEN'(sad8_q[1]) + PSAD_LEN'(sad8_q[2]) + PSAD_LEN'(sad8_q[3]);
    psad[P16X8_0] = PSAD_LEN'(sad8_q[0]) + PSAD_LEN'(sad8_q[1]);
    psad[P16X8_1] = PSAD_LEN'(sad8_q[2]) + PSAD_LEN'(sad8_q[3]);
    psad[P8X16_0] = PSAD_LEN'(sad8_q[0]) + PSAD_LEN'(sad8_q[2]);
    psad[P8X16_1] = PSAD_LEN'(sad8_q[1]) + PSAD_LEN'(sad8_q[3]);
    for (int i = 0; i < 4; i++) psad[P8X8_0+i] = PSAD_LEN'(sad8_q[i]);
    bus.best_cost_o = '0;
    bus.best_mv_o = '0;
    for (int p = 0; p < PART_NUM; p++) begin
      cost[p] = sat_cost(psad[p] + PSAD_LEN'(mvc_q));
      bus.best_cost_o[p*COST_LEN +: COST_LEN] = best_cost_q[p];
      bus.best_mv_o[p*2*MV_LEN +: 2*MV_LEN] = best_mv_q[p];
    end
    bus.busy_o = state_q != IDLE;
    bus.done_o = done_q;
  end

  // start_i dominates stage 2: clears bests and squashes whatever stage 1 held
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      done_q <= 1'b0;
      mvc_q <= '0;
      mv_q <= '0;
      for (int i = 0; i < 4; i++) sad8_q[i] <= '0;
      for (int p = 0; p < PART_NUM; p++) begin
        best_cost_q[p] <= '1;
        best_mv_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      s1_valid_q <= acc;
      done_q <= s1_valid_q && s1_last_q && !bus.start_i;
      if (acc) begin
        s1_last_q <= bus.last_i;
        mvc_q <= mvc_d;
        mv_q <= {bus.mv_y_i, bus.mv_x_i};
        sad8_q <= sad8_d;
      end
      for (int p = 0; p < PART_NUM; p++)
        if (bus.start_i) begin
          best_cost_q[p] <= '1;
          best_mv_q[p] <= '0;
        end else if (s1_valid_q && cost[p] < best_cost_q[p]) begin
          best_cost_q[p] <= cost[p];
          best_mv_q[p] <= mv_q;
        end
    end
  end
endmodule

// File: tb/tb_ime_best_mv.sv
// tb_ime_best_mv: scoreboard bench; expected winners queued per search, popped on done_o
module tb_ime_best_mv;
  import ime_best_mv_pkg::*;
  typedef struct packed {
    logic [PART_NUM*COST_LEN-1:0] cost;
    logic [PART_NUM*2*MV_LEN-1:0] mv;
  } res_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int errors = 0;
  int checks = 0;
  res_t exp_q[$];
  int sad[16];
  int lam, pmvx, pmvy;
  int mdl_cost[9];
  logic [2*MV_LEN-1:0] mdl_mv[9];
  logic [3:0] masks[9] = '{4'b1111, 4'b0011, 4'b1100, 4'b0101, 4'b1010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  ime_best_mv_if bus();
  ime_best_mv dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    res_t r;
    if (bus.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_done: done_o=1 with no search expected");
      end else begin
        r = exp_q.pop_front();
        for (int p = 0; p < 9; p++) begin
          checks++;
          if (bus.best_cost_o[p*16 +: 16] !== r.cost[p*16 +: 16]) begin
            errors++;
            $display("FAIL sb_cost[%0d]: got %0d want %0d", p, bus.best_cost_o[p*16 +: 16], r.cost[p*16 +: 16]);
          end
          checks++;
          if (bus.best_mv_o[p*14 +: 14] !== r.mv[p*14 +: 14]) begin
            errors++;
            $display("FAIL sb_mv[%0d]: got %h want %h", p, bus.best_mv_o[p*14 +: 14], r.mv[p*14 +: 14]);
          end
        end
      end
    end
  end

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 9; p++) begin
      mdl_cost[p] = 65535;
      mdl_mv[p] = '0;
    end
  endtask

  task automatic model_cand(input int mvx, input int mvy);
    int s8[4];
    int c, mvc;
    for (int b = 0; b < 4; b++) s8[b] = sad[4*b] + sad[4*b+1] + sad[4*b+2] + sad[4*b+3];
    mvc = lam * (iabs(mvx - pmvx) + iabs(mvy - pmvy));
    for (int p = 0; p < 9; p++) begin
      c = mvc;
      for (int b = 0; b < 4; b++) if (masks[p][b]) c += s8[b];
      if (c > 65535) c = 65535;
      if (c < mdl_cost[p]) begin
        mdl_cost[p] = c;
        mdl_mv[p] = {7'(mvy), 7'(mvx)};
      end
    end
  endtask

  task automatic set_params(input int l, input int px, input int py);
    lam = l; pmvx = px; pmvy = py;
    bus.lambda_i = 6'(l); bus.pmv_x_i = 7'(px); bus.pmv_y_i = 7'(py);
  endtask

  task automatic do_start();
    model_clear();
    bus.start_i = 1'b1; bus.valid_i = 1'b0; bus.last_i = 1'b0;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic apply(input int mvx, input int mvy, input bit last, input bit st);
    res_t r;
    if (st) model_clear();
    model_cand(mvx, mvy);
    if (last) begin
      for (int p = 0; p < 9; p++) begin
        r.cost[p*16 +: 16] = 16'(mdl_cost[p]);
        r.mv[p*14 +: 14] = mdl_mv[p];
      end
      exp_q.push_back(r);
    end
    for (int k = 0; k < 16; k++) bus.sad4x4_i[k*13 +: 13] = 13'(sad[k]);
    bus.mv_x_i = 7'(mvx); bus.mv_y_i = 7'(mvy);
    bus.start_i = st; bus.valid_i = 1'b1; bus.last_i = last;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.valid_i = 1'b0; bus.last_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #2;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.best_cost_o !== {144{1'b1}}) begin errors++; $display("FAIL reset_cost: got %h want all ones", bus.best_cost_o); end
    checks++; if (bus.best_mv_o !== 126'd0) begin errors++; $display("FAIL reset_mv: got %h want 0", bus.best_mv_o); end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_basic();
    set_params(4, 0, 0);
    for (int k = 0; k < 16; k++) sad[k] = 1;
    do_start();
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy_o); end
    apply(0, 0, 1, 0);
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", bus.done_o); end
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL basic_done_lat: got %b want 1", bus.done_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", bus.busy_o); end
    checks++; if (bus.best_cost_o[0 +: 16] !== 16'd16) begin errors++; $display("FAIL basic_p0: got %0d want 16", bus.best_cost_o[0 +: 16]); end
    checks++; if (bus.best_cost_o[16 +: 16] !== 16'd8) begin errors++; $display("FAIL basic_p1: got %0d want 8", bus.best_cost_o[16 +: 16]); end
    checks++; if (bus.best_cost_o[80 +: 16] !== 16'd4) begin errors++; $display("FAIL basic_p5: got %0d want 4", bus.best_cost_o[80 +: 16]); end
  endtask

  task automatic test_tie();
    set_params(0, 0, 0);
    for (int k = 0; k < 16; k++) sad[k] = 0;
    do_start();
    sad[0] = 500; apply(1, 1, 0, 0);
    sad[0] = 300; apply(2, 2, 0, 0);
    sad[0] = 300; apply(3, 3, 1, 0);
    @(negedge clk); @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL tie_done: got %b want 1", bus.done_o); end
    checks++; if (bus.best_mv_o[0 +: 14] !== {7'd2, 7'd2}) begin errors++; $display("FAIL tie_p0_mv: got %h want %h", bus.best_mv_o[0 +: 14], {7'd2, 7'd2}); end
    checks++; if (bus.best_cost_o[0 +: 16] !== 16'd300) begin errors++; $display("FAIL tie_p0_cost: got %0d want 300", bus.best_cost_o[0 +: 16]); end
  endtask

  task automatic test_partition();
    set_params(0, 0, 0);
    do_start();
    for (int k = 0; k < 16; k++) sad[k] = k < 4 ? 1 : 50;
    apply(5, -3, 0, 0);
    for (int k = 0; k < 16; k++) sad[k] = k >= 12 ? 1 : 40;
    apply(-7, 9, 1, 0);
    @(negedge clk); @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL part_done: got %b want 1", bus.done_o); end
    checks++; if (bus.best_mv_o[5*14 +: 14] !== {7'(-3), 7'(5)}) begin errors++; $display("FAIL part_p5_mv: got %h want A", bus.best_mv_o[5*14 +: 14]); end
    checks++; if (bus.best_mv_o[8*14 +: 14] !== {7'(9), 7'(-7)}) begin errors++; $display("FAIL part_p8_mv: got %h want B", bus.best_mv_o[8*14 +: 14]); end
    checks++; if (bus.best_mv_o[0 +: 14] !== {7'(9), 7'(-7)}) begin errors++; $display("FAIL part_p0_mv: got %h want B", bus.best_mv_o[0 +: 14]); end
  endtask

  task automatic test_sat();
    set_params(63, -64, 63);
    for (int k = 0; k < 16; k++) sad[k] = 4080;
    do_start();
    apply(63, -64, 1, 0);
    @(negedge clk); @(negedge clk);
    checks++; if (bus.best_cost_o[0 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL sat_p0: got %0d want 65535", bus.best_cost_o[0 +: 16]); end
    checks++; if (bus.best_cost_o[80 +: 16] !== 16'd32322) begin errors++; $display("FAIL sat_p5: got %0d want 32322", bus.best_cost_o[80 +: 16]); end
  endtask

  task automatic test_squash();
    set_params(2, 1, 1);
    for (int k = 0; k < 16; k++) sad[k] = 3;
    do_start();
    apply(4, 4, 0, 0);
    do_start();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL squash_busy: got %b want 1", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL squash_done: got %b want 0", bus.done_o); end
      checks++; if (bus.best_cost_o !== {144{1'b1}}) begin errors++; $display("FAIL squash_cost: got %h want all ones", bus.best_cost_o); end
    end
    apply(-2, 3, 1, 0);
    @(negedge clk); @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL squash_end_done: got %b want 1", bus.done_o); end
  endtask

  task automatic test_idle();
    logic [PART_NUM*COST_LEN-1:0] sc;
    logic [PART_NUM*2*MV_LEN-1:0] sm;
    sc = bus.best_cost_o; sm = bus.best_mv_o;
    for (int k = 0; k < 16; k++) begin sad[k] = 0; bus.sad4x4_i[k*13 +: 13] = 13'd0; end
    bus.mv_x_i = 7'd11; bus.mv_y_i = 7'd12;
    bus.valid_i = 1'b1; bus.last_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.last_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL idle_done: got %b want 0", bus.done_o); end
    end
    checks++; if (bus.best_cost_o !== sc) begin errors++; $display("FAIL idle_cost: got %h want %h", bus.best_cost_o, sc); end
    checks++; if (bus.best_mv_o !== sm) begin errors++; $display("FAIL idle_mv: got %h want %h", bus.best_mv_o, sm); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy_o); end
    set_params(1, 0, 0);
    for (int k = 0; k < 16; k++) sad[k] = k;
    apply(4, -4, 1, 1);
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL sv_done_early: got %b want 0", bus.done_o); end
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL sv_done_lat: got %b want 1", bus.done_o); end
  endtask

  task automatic test_restart();
    set_params(3, 2, -2);
    do_start();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) sad[k] = int'($urandom_range(200));
      apply(i, -i, 0, 0);
    end
    for (int k = 0; k < 16; k++) sad[k] = 500;
    apply(10, 10, 0, 1);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", bus.busy_o); end
    for (int k = 0; k < 16; k++) sad[k] = 600;
    apply(-1, 1, 1, 0);
    @(negedge clk); @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", bus.done_o); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      set_params(int'($urandom_range(63)), int'($urandom_range(127)) - 64, int'($urandom_range(127)) - 64);
      do_start();
      for (int i = 0; i < 8; i++) begin
        for (int k = 0; k < 16; k++) sad[k] = int'($urandom_range(4080));
        apply(int'($urandom_range(127)) - 64, int'($urandom_range(127)) - 64, i == 7, 0);
      end
      @(negedge clk); @(negedge clk);
      checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b want 1", r, bus.done_o); end
    end
  endtask

  task automatic test_async_reset();
    set_params(1, 0, 0);
    for (int k = 0; k < 16; k++) sad[k] = 2;
    do_start();
    apply(1, 1, 0, 0);
    #3 rstn = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.best_cost_o !== {144{1'b1}}) begin errors++; $display("FAIL arst_cost: got %h want all ones", bus.best_cost_o); end
    checks++; if (bus.best_mv_o !== 126'd0) begin errors++; $display("FAIL arst_mv: got %h want 0", bus.best_mv_o); end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.best_cost_o !== {144{1'b1}}) begin errors++; $display("FAIL arst_after: got %h want all ones", bus.best_cost_o); end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.sad4x4_i = '0;
    bus.mv_x_i = '0; bus.mv_y_i = '0; bus.pmv_x_i = '0; bus.pmv_y_i = '0; bus.lambda_i = '0;
    test_reset();
    test_basic();
    test_tie();
    test_partition();
    test_sat();
    test_squash();
    test_idle();
    test_restart();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
